// File: rtl/sifh_threshold_scheduler_pkg.sv
// Shared widths and FSM encodings for the SiFH threshold scheduler.
package sifh_threshold_scheduler_pkg;

    localparam int Nb             = 8;
    localparam int Np             = 12;
    localparam int PixelNumPerRam = 4;

    typedef enum logic [1:0] {
        TS_IDLE = 2'd0,
        TS_CALC = 2'd1,
        TS_OUT  = 2'd2
    } tsState_e;

endpackage

// File: rtl/sifh_threshold_scheduler_if.sv
// Window result channel from the scheduler to the fine-histogram configuration stage.
interface sifh_threshold_scheduler_if #(
    parameter int NP = sifh_threshold_scheduler_pkg::Np,
    parameter int PW = 2
);
    logic          th_valid;
    logic          th_ready;
    logic [PW-1:0] th_pixel;
    logic [NP-1:0] th_minus;
    logic [NP-1:0] th_positive;
    logic [NP-1:0] delta;

    modport master (
        output th_valid, th_pixel, th_minus, th_positive, delta,
        input  th_ready
    );

    modport slave (
        input  th_valid, th_pixel, th_minus, th_positive, delta,
        output th_ready
    );
endinterface

// File: rtl/sifh_window_calc.sv
// Combinational fine-resolution search window: clamped bounds around the coarse peak plus delta.
module sifh_window_calc #(
    parameter int NB = sifh_threshold_scheduler_pkg::Nb,
    parameter int NP = sifh_threshold_scheduler_pkg::Np
) (
    input  logic [NB-1:0] peak,
    output logic [NP-1:0] thMinus,
    output logic [NP-1:0] thPositive,
    output logic [NP-1:0] delta
);
    localparam logic [NP-1:0] SB    = NP'(3 << (NB - 2));
    localparam logic [NP-1:0] SB2   = NP'(3 << (NB - 1));
    localparam logic [NP-1:0] MAXV  = {NP{1'b1}};
    localparam logic [NP-1:0] HIEDG = MAXV - SB;

    logic [NP-1:0] ch;
    logic [NP-1:0] lo;
    logic [NP-1:0] hi;
    logic [NP-1:0] hiFloor;

    always_comb begin
        ch = {peak, {(NP - NB){1'b0}}};
        if (ch <= SB) begin
            lo = '0;
            hi = SB2;
        end else if (ch >= HIEDG) begin
            hi = MAXV;
            lo = MAXV - SB2;
        end else begin
            lo = ch - SB;
            hi = ch + SB;
        end
        // Delta wraps modulo 2^NP by construction of the NP-wide sum.
        hiFloor    = (hi >> NB) << NB;
        delta      = lo + hi - hiFloor;
        thMinus    = lo;
        thPositive = hi;
    end
endmodule

// File: rtl/sifh_threshold_scheduler.sv
// Round-robin arbiter over per-pixel peak results; issues one registered search window per pixel per frame.
module sifh_threshold_scheduler
    import sifh_threshold_scheduler_pkg::*;
#(
    parameter int NB     = Nb,
    parameter int NP     = Np,
    parameter int PIXELS = PixelNumPerRam,
    parameter int PW     = $clog2(PIXELS)
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 frame_start,
    input  logic [PIXELS-1:0]    peak_valid,
    input  logic [PIXELS*NB-1:0] peak_ch,
    output logic [PIXELS-1:0]    peak_ready,
    sifh_threshold_scheduler_if.master thIf,
    output logic                 busy,
    output logic                 frame_done
);
    tsState_e            state;
    tsState_e            nextState;
    logic [PW-1:0]       rrPtr;
    logic [PW-1:0]       grantPix;
    logic [PW-1:0]       reqPix;
    logic [PW-1:0]       nextPtr;
    logic                reqFound;
    logic                accept;
    logic                handshake;
    logic                allDoneSeen;
    logic [PIXELS-1:0]   doneMask;
    logic [PIXELS-1:0]   rotated;
    logic [2*PIXELS-1:0] eligible2;
    logic [PW:0]         pixSum;
    logic [PW:0]         ptrSum;
    logic [NB-1:0]       peakLatch;
    logic [NP-1:0]       calcMinus;
    logic [NP-1:0]       calcPositive;
    logic [NP-1:0]       calcDelta;

    sifh_window_calc #(.NB(NB), .NP(NP)) u_calc (
        .peak       (peakLatch),
        .thMinus    (calcMinus),
        .thPositive (calcPositive),
        .delta      (calcDelta)
    );

    // Rotate eligibility so offset 0 is rrPtr; the lowest set offset wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        eligible2 = {2{peak_valid & ~doneMask}} >> rrPtr;
        rotated   = eligible2[PIXELS-1:0];
        reqFound  = 1'b0;
        pixSum    = '0;
        for (int i = PIXELS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                reqFound = 1'b1;
                pixSum   = {1'b0, rrPtr} + (PW + 1)'(i);
            end
        end
        if (pixSum >= (PW + 1)'(PIXELS)) pixSum = pixSum - (PW + 1)'(PIXELS);
        reqPix = pixSum[PW-1:0];

        ptrSum = {1'b0, grantPix} + (PW + 1)'(1);
        if (ptrSum >= (PW + 1)'(PIXELS)) ptrSum = '0;
        nextPtr = ptrSum[PW-1:0];
    end

    assign accept    = (state == TS_IDLE) && reqFound;
    assign handshake = (state == TS_OUT) && thIf.th_ready;

    // Grant is gated by res so peak_ready reads 0 while held in reset.
    always_comb begin
        peak_ready = '0;
        if (res && accept) peak_ready[reqPix] = 1'b1;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            TS_IDLE: if (reqFound) nextState = TS_CALC;
            TS_CALC: nextState = TS_OUT;
            TS_OUT:  if (thIf.th_ready) nextState = TS_IDLE;
            default: nextState = TS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state            <= TS_IDLE;
            rrPtr            <= '0;
            grantPix         <= '0;
            doneMask         <= '0;
            peakLatch        <= '0;
            allDoneSeen      <= 1'b0;
            busy             <= 1'b0;
            frame_done       <= 1'b0;
            thIf.th_valid    <= 1'b0;
            thIf.th_pixel    <= '0;
            thIf.th_minus    <= '0;
            thIf.th_positive <= '0;
            thIf.delta       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state         <= nextState;
            busy          <= (nextState != TS_IDLE);
            thIf.th_valid <= (nextState == TS_OUT);
            if (accept) begin
                peakLatch <= peak_ch[reqPix*NB +: NB];
                grantPix  <= reqPix;
            end
            if (state == TS_CALC) begin
                thIf.th_pixel    <= grantPix;
                thIf.th_minus    <= calcMinus;
                thIf.th_positive <= calcPositive;
                thIf.delta       <= calcDelta;
            end
            if (handshake) rrPtr <= nextPtr;
            // A new frame beats a coinciding delivery, leaving that pixel eligible again.
            if (frame_start)    doneMask           <= '0;
            else if (handshake) doneMask[grantPix] <= 1'b1;
            allDoneSeen <= &doneMask;
            frame_done  <= (&doneMask) && !allDoneSeen;
        end
    end
endmodule

// File: tb/tb_sifh_threshold_scheduler.sv
// Self-checking bench for sifh_threshold_scheduler: vector table, scoreboard and multi-cycle sequences.
module tb_sifh_threshold_scheduler;
    localparam int NB     = 8;
    localparam int NP     = 12;
    localparam int PIXELS = 4;
    localparam int PW     = 2;

    typedef struct {
        int pixel;
        int minus;
        int pos;
        int delta;
    } exp_t;

    typedef struct {
        exp_t e;
        exp_t o;
        bit   haveExp;
    } pair_t;

    typedef struct {
        int         pixel;
        logic [7:0] peak;
        int         minus;
        int         pos;
        int         delta;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 res = 1'b0;
    logic                 frame_start = 1'b0;
    logic [PIXELS-1:0]    peak_valid = '0;
    logic [PIXELS*NB-1:0] peak_ch = '0;
    logic [PIXELS-1:0]    peak_ready;
    logic                 busy;
    logic                 frame_done;

    int nVec = 0;
    int nErr = 0;
    int cycle = 0;
    int frameDoneCnt = 0;
    int pairIdx = 0;
    exp_t  sbQ[$];
    pair_t pairQ[$];
    int    grantIdQ[$];
    int    grantCycQ[$];

    sifh_threshold_scheduler_if #(.NP(NP), .PW(PW)) thIf ();

    sifh_threshold_scheduler #(.NB(NB), .NP(NP), .PIXELS(PIXELS), .PW(PW)) dut (
        .clk         (clk),
        .res         (res),
        .frame_start (frame_start),
        .peak_valid  (peak_valid),
        .peak_ch     (peak_ch),
        .peak_ready  (peak_ready),
        .thIf        (thIf),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic exp_t modelWindow(int pixel, int peak);
        int ch, lo, hi;
        exp_t e;
        ch = peak * 16;
        if (ch <= 192) begin
            lo = 0;
            hi = 384;
        end else if (ch >= 4095 - 192) begin
            hi = 4095;
            lo = 4095 - 384;
        end else begin
            lo = ch - 192;
            hi = ch + 192;
        end
        e.pixel = pixel;
        e.minus = lo;
        e.pos   = hi;
        e.delta = (lo + hi - (hi / 256) * 256) % 4096;
        return e;
    endfunction

    // Monitor: expected windows pushed at accept, matched against each delivered result.
    always @(negedge clk) begin
        if (!res) begin
            sbQ.delete();
        end else begin
            if (thIf.th_valid && thIf.th_ready) begin
                pair_t p;
                p.o.pixel = int'(thIf.th_pixel);
                p.o.minus = int'(thIf.th_minus);
                p.o.pos   = int'(thIf.th_positive);
                p.o.delta = int'(thIf.delta);
                p.haveExp = (sbQ.size() > 0);
                if (p.haveExp) p.e = sbQ.pop_front();
                else           p.e = '{default: 0};
                pairQ.push_back(p);
            end
            for (int i = 0; i < PIXELS; i++) begin
                if (peak_ready[i] && peak_valid[i]) begin
                    sbQ.push_back(modelWindow(i, int'(peak_ch[i*NB +: NB])));
                    grantIdQ.push_back(i);
                    grantCycQ.push_back(cycle);
                end
            end
            if (frame_done) frameDoneCnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nErr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drain();
        while (pairIdx < pairQ.size()) begin
            pair_t p;
            p = pairQ[pairIdx];
            pairIdx++;
            check("sb_has_expected", p.haveExp, 1'b1);
            if (p.haveExp) begin
                check("sb_pixel", p.o.pixel, p.e.pixel);
                check("sb_minus", p.o.minus, p.e.minus);
                check("sb_positive", p.o.pos, p.e.pos);
                check("sb_delta", p.o.delta, p.e.delta);
            end
        end
    endtask

    task automatic waitGrant(output int id);
        bit found;
        found = 1'b0;
        id = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (|(peak_ready & peak_valid)) begin
                found = 1'b1;
                break;
            end
        end
        check("grant_seen", found, 1'b1);
        for (int i = PIXELS - 1; i >= 0; i--) if (peak_ready[i]) id = i;
    endtask

    task automatic pulseFrameStart(input logic [PIXELS-1:0] validAfter);
        @(posedge clk); #1;
        frame_start = 1'b1;
        peak_valid  = '0;
        @(posedge clk); #1;
        frame_start = 1'b0;
        peak_valid  = validAfter;
    endtask

    task automatic checkZeroOutputs(input string tag);
        check({tag, "_peak_ready"}, peak_ready, 0);
        check({tag, "_th_valid"}, thIf.th_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_frame_done"}, frame_done, 0);
        check({tag, "_th_pixel"}, thIf.th_pixel, 0);
        check({tag, "_th_minus"}, thIf.th_minus, 0);
        check({tag, "_th_positive"}, thIf.th_positive, 0);
        check({tag, "_delta"}, thIf.delta, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   g, nxt, fd0;
        exp_t e;
        logic [31:0] initCh;

        tbl[0] = '{pixel: 0, peak: 8'h40, minus: 'h340, pos: 'h4C0, delta: 'h400};
        tbl[1] = '{pixel: 1, peak: 8'h05, minus: 'h000, pos: 'h180, delta: 'h080};
        tbl[2] = '{pixel: 2, peak: 8'hFF, minus: 'hE7F, pos: 'hFFF, delta: 'hF7E};
        tbl[3] = '{pixel: 3, peak: 8'h0C, minus: 'h000, pos: 'h180, delta: 'h080};
        tbl[4] = '{pixel: 0, peak: 8'h0D, minus: 'h010, pos: 'h190, delta: 'h0A0};
        tbl[5] = '{pixel: 1, peak: 8'hF4, minus: 'hE7F, pos: 'hFFF, delta: 'hF7E};
        tbl[6] = '{pixel: 2, peak: 8'hF3, minus: 'hE70, pos: 'hFF0, delta: 'hF60};
        tbl[7] = '{pixel: 3, peak: 8'h80, minus: 'h740, pos: 'h8C0, delta: 'h800};
        initCh = 32'h80FF0540;

        // Reset state with every pixel requesting; then round robin from reset.
        thIf.th_ready = 1'b1;
        peak_valid    = '1;
        peak_ch       = initCh;
        repeat (2) @(negedge clk);
        checkZeroOutputs("reset");
        fd0 = frameDoneCnt;
        @(posedge clk); #1;
        res = 1'b1;
        repeat (20) @(negedge clk);
        check("rr_grant_count", grantIdQ.size(), 4);
        for (int i = 0; i < 4 && i < grantIdQ.size(); i++) begin
            check("rr_grant_order", grantIdQ[i], i);
            if (i > 0) check("rr_grant_spacing", grantCycQ[i] - grantCycQ[i-1], 3);
        end
        check("rr_frame_done_once", frameDoneCnt - fd0, 1);
        drain();

        // Table of single-pixel windows, one frame per vector.
        for (int v = 0; v < 8; v++) begin
            @(posedge clk); #1;
            frame_start = 1'b1;
            peak_valid  = '0;
            @(posedge clk); #1;
            frame_start = 1'b0;
            peak_ch[tbl[v].pixel*NB +: NB] = tbl[v].peak;
            peak_valid = PIXELS'(1 << tbl[v].pixel);
            waitGrant(g);
            check("tbl_grant_onehot", peak_ready, 1 << tbl[v].pixel);
            @(posedge clk); #1;
            peak_valid = '0;
            @(negedge clk);
            check("tbl_calc_not_valid", thIf.th_valid, 0);
            check("tbl_calc_busy", busy, 1);
            @(negedge clk);
            check("tbl_latency_valid", thIf.th_valid, 1);
            check("tbl_th_pixel", thIf.th_pixel, tbl[v].pixel);
            check("tbl_th_minus", thIf.th_minus, tbl[v].minus);
            check("tbl_th_positive", thIf.th_positive, tbl[v].pos);
            check("tbl_delta", thIf.delta, tbl[v].delta);
        end

        // Back-pressure: hold OUT for several cycles, then release.
        @(posedge clk); #1;
        thIf.th_ready = 1'b0;
        frame_start   = 1'b1;
        peak_ch       = initCh;
        @(posedge clk); #1;
        frame_start = 1'b0;
        peak_valid  = '1;
        waitGrant(g);
        nxt = (g + 1) % PIXELS;
        e = modelWindow(g, int'(peak_ch[g*NB +: NB]));
        @(negedge clk);
        @(negedge clk);
        check("hold_enter_valid", thIf.th_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", thIf.th_valid, 1);
            check("hold_pixel", thIf.th_pixel, g);
            check("hold_minus", thIf.th_minus, e.minus);
            check("hold_delta", thIf.delta, e.delta);
            check("hold_no_grant", peak_ready, 0);
        end
        @(posedge clk); #1;
        thIf.th_ready = 1'b1;
        @(negedge clk);
        check("hold_release_valid", thIf.th_valid, 1);
        @(negedge clk);
        check("hold_next_grant", peak_ready, 1 << nxt);
        repeat (12) @(negedge clk);
        drain();

        // frame_start while pixel 2 is in CALC: result still delivered.
        pulseFrameStart(4'b0100);
        waitGrant(g);
        check("calc_fs_grant", g, 2);
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("calc_fs_valid", thIf.th_valid, 1);
        check("calc_fs_pixel", thIf.th_pixel, 2);
        repeat (3) @(negedge clk);

        // frame_start coinciding with the OUT handshake: pixel 2 stays eligible.
        pulseFrameStart(4'b0100);
        waitGrant(g);
        check("coin_grant", g, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(negedge clk);
        check("coin_out_valid", thIf.th_valid, 1);
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        check("coin_regrant", peak_ready, 4'b0100);
        repeat (4) @(negedge clk);
        drain();

        // Reset asserted in OUT: outputs clear and the done mask is forgotten.
        pulseFrameStart(4'b0001);
        waitGrant(g);
        check("rst_first_grant", g, 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        thIf.th_ready = 1'b0;
        peak_valid    = 4'b0010;
        waitGrant(g);
        check("rst_second_grant", g, 1);
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", thIf.th_valid, 1);
        drain();
        @(posedge clk); #1;
        res        = 1'b0;
        peak_valid = 4'b0001;
        @(negedge clk);
        checkZeroOutputs("midrst");
        @(posedge clk); #1;
        res = 1'b1;
        thIf.th_ready = 1'b1;
        waitGrant(g);
        check("midrst_mask_cleared", g, 0);
        @(posedge clk); #1;
        peak_valid = '0;
        repeat (5) @(negedge clk);
        drain();
        check("sb_leftover", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
